bcnn_frame_streamer: RTL and testbench

Hardware pixel source for the BCNN conv3x3 → binarizer → maxpool2x2 chain. A host writes a binary frame one row per cycle into an internal row memory. On `start`, the block streams the frame in raster order as a 1-bit `pixel_out`/`valid_out` stream, one pixel per cycle, with an optional stall. It then waits a programmable drain interval so the downstream pipeline can flush, and pulses `done`. The block replaces the behavioural pixel-streaming loop with synthesizable RTL, and its output ports connect directly to `bcnn_conv3x3_top` `pixel_in`/`valid_in`.

---
 rtl/bcnn_stream_pkg.sv | 25 ++
 rtl/bcnn_row_mem.sv | 24 ++
 rtl/bcnn_frame_streamer.sv | 143 ++++++++++++++
 tb/tb_bcnn_frame_streamer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcnn_stream_pkg.sv
// Shared types and width helpers for the BCNN frame streamer.
package bcnn_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } stream_state_e;

  // Index width for a dimension of n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Drain counter must be able to hold the value d itself.
  function automatic int unsigned drain_w(input int unsigned d);
    return (d > 0) ? $clog2(d + 1) : 1;
  endfunction

  localparam int unsigned ROW_W   = idx_w(28);
  localparam int unsigned COL_W   = idx_w(28);
  localparam int unsigned DRAIN_W = drain_w(50);

endpackage

// File: rtl/bcnn_row_mem.sv
// Frame row store: one write port, one registered read port, storage not reset.
module bcnn_row_mem #(
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [IMG_WIDTH-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [IMG_WIDTH-1:0]  rd_data
);

  logic [IMG_WIDTH-1:0] mem [IMG_HEIGHT];

  // Synchronous write and registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bcnn_frame_streamer.sv
// Streams a stored binary frame in raster order as a 1-bit pixel/valid stream,
// then waits a drain interval and pulses done.
module bcnn_frame_streamer
  import bcnn_stream_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = 28,
  parameter int unsigned IMG_HEIGHT   = 28,
  parameter int unsigned DRAIN_CYCLES = 50
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [idx_w(IMG_HEIGHT)-1:0]  wr_row,
  input  logic [IMG_WIDTH-1:0]          wr_data,
  input  logic                          start,
  input  logic                          hold,
  output logic                          pixel_out,
  output logic                          valid_out,
  output logic [idx_w(IMG_HEIGHT)-1:0]  row_idx,
  output logic [idx_w(IMG_WIDTH)-1:0]   col_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned RW = idx_w(IMG_HEIGHT);
  localparam int unsigned CW = idx_w(IMG_WIDTH);
  localparam int unsigned DW = drain_w(DRAIN_CYCLES);

  stream_state_e state, state_next;

  logic [RW-1:0]        row_cnt;
  logic [CW-1:0]        col_cnt;
  logic [DW-1:0]        drain_cnt;
  logic [IMG_WIDTH-1:0] cur_row;
  logic [IMG_WIDTH-1:0] rd_data;
  logic [RW-1:0]        rd_addr;
  logic                 rd_en;
  logic                 mem_we;
  logic                 emit;
  logic                 last_col;
  logic                 last_row;
  logic                 last_px;
  logic                 drain_end;
  logic                 pend_px;

  assign mem_we    = wr_en && (state == IDLE) && (32'(wr_row) < IMG_HEIGHT);
  assign emit      = (state == STREAM) && !hold;
  assign last_col  = (col_cnt == CW'(IMG_WIDTH - 1));
  assign last_row  = (row_cnt == RW'(IMG_HEIGHT - 1));
  assign last_px   = emit && last_row && last_col;
  assign drain_end = (state == DRAIN) && (drain_cnt == DW'(DRAIN_CYCLES));

  // The read port always holds the row that column 0 of the pending row
  // needs: row 0 is read in FETCH, and each emitted pixel re-reads row r+1.
  // Reads are suppressed while stalled so that prefetched row is not lost.
  assign rd_en   = (state == FETCH) || emit;
  assign rd_addr = (state == FETCH) ? '0 : (last_row ? row_cnt : row_cnt + RW'(1));

  // Column 0 comes straight from the read port; later columns from the latched row.
  assign pend_px = (col_cnt == '0) ? rd_data[0] : cur_row[col_cnt];

  bcnn_row_mem #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .ADDR_W     (RW)
  ) u_row_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_row),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = STREAM;
      STREAM:  if (last_px) state_next = DRAIN;
      DRAIN:   if (drain_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster counters, row latch and drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      drain_cnt <= '0;
      cur_row   <= '0;
    end else begin
      if (state == FETCH) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (emit) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (emit && (col_cnt == '0)) cur_row <= rd_data;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // Registered outputs; during a stall they present the pending pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out <= 1'b0;
      valid_out <= 1'b0;
      row_idx   <= '0;
      col_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= emit;
      if (state == STREAM) begin
        pixel_out <= pend_px;
        row_idx   <= row_cnt;
        col_idx   <= col_cnt;
      end else begin
        pixel_out <= 1'b0;
        row_idx   <= '0;
        col_idx   <= '0;
      end
      busy <= (state_next != IDLE);
      done <= drain_end;
    end
  end

endmodule

// File: tb/tb_bcnn_frame_streamer.sv
// Self-checking bench for bcnn_frame_streamer.
module tb_bcnn_frame_streamer;

  localparam int unsigned W  = 28;
  localparam int unsigned H  = 28;
  localparam int unsigned D  = 50;
  localparam int unsigned WH = W * H;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, hold;
  logic [4:0]    wr_row;
  logic [W-1:0]  wr_data;
  logic          pixel_out, valid_out, busy, done;
  logic [4:0]    row_idx, col_idx;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [W-1:0] ref_mem [H];

  bcnn_frame_streamer #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .start     (start),
    .hold      (hold),
    .pixel_out (pixel_out),
    .valid_out (valid_out),
    .row_idx   (row_idx),
    .col_idx   (col_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write one row in IDLE; the model ignores out-of-range rows.
  task automatic write_row(input int unsigned r, input logic [W-1:0] d);
    wr_en = 1'b1; wr_row = 5'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (r < H) ref_mem[r] = d;
  endtask

  // One full frame checked against the model: pixels in raster order from
  // ref_mem, one pixel per non-held streaming edge, done D+1 edges after the
  // last pixel edge.
  task automatic run_frame(input string tag, input int unsigned hold_pct,
                           input bit inject, input bit wr_same);
    int unsigned emitted, holds, end_cyc, cyc, r, c;
    bit h, fin;
    logic [W-1:0] nd;
    emitted = 0; holds = 0; end_cyc = 0; cyc = 0; fin = 1'b0;
    if (wr_same) begin
      nd = W'($urandom);
      wr_en = 1'b1; wr_row = 5'd0; wr_data = nd;
      ref_mem[0] = nd;
    end
    start = 1'b1; hold = 1'b0;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " valid_after_start"}, valid_out, 0);
    while (!fin) begin
      cyc++;
      h = ($urandom_range(0, 99) < hold_pct);
      hold = h;
      if (inject && cyc >= 2) begin
        start   = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        wr_row  = 5'($urandom_range(0, H - 1));
        wr_data = W'($urandom);
      end
      @(negedge clk);
      if (cyc >= 2 && emitted < WH) begin
        r = emitted / W; c = emitted % W;
        if (h) begin
          holds++;
          check({tag, " hold_valid"}, valid_out, 0);
        end else begin
          check({tag, " stream_valid"}, valid_out, 1);
          emitted++;
          if (emitted == WH) end_cyc = cyc + 1 + D;
        end
        check({tag, " row_idx"}, row_idx, r);
        check({tag, " col_idx"}, col_idx, c);
        check({tag, " pixel"}, pixel_out, ref_mem[r][c]);
      end else begin
        check({tag, " quiet_valid"}, valid_out, 0);
      end
      fin = (end_cyc != 0) && (cyc == end_cyc);
      check({tag, " done"}, done, fin);
      check({tag, " busy"}, busy, !fin);
      if (!fin && cyc > 2 * WH + D + 100) begin
        check({tag, " timeout"}, 1, 0);
        fin = 1'b1;
      end
    end
    hold = 1'b0; start = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check({tag, " no_restart_busy"}, busy, 0);
    check({tag, " done_single"}, done, 0);
    check({tag, " no_restart_valid"}, valid_out, 0);
  endtask

  typedef struct {
    string      name;
    bit         rst, st, hd;
    bit         e_busy, e_valid, e_done;
    logic [4:0] e_row, e_col;
    bit         e_px;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int unsigned guard;
    reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Checkerboard: row r bit c = (r+c) mod 2.
    for (int unsigned r = 0; r < H; r++) begin
      logic [W-1:0] d;
      for (int unsigned c = 0; c < W; c++) d[c] = 1'((r + c) % 2);
      write_row(r, d);
    end

    // Cycle script: reset, idle hold, start, FETCH, first pixel, stall, reset.
    vecs[0] = '{"v_reset",     1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0};
    vecs[1] = '{"v_idle_hold", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0};
    vecs[2] = '{"v_start",     0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 0};
    vecs[3] = '{"v_fetch",     0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0};
    vecs[4] = '{"v_px00",      0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 0};
    vecs[5] = '{"v_hold01",    0, 0, 1, 1, 0, 0, 5'd0, 5'd1, 1};
    vecs[6] = '{"v_px01",      0, 0, 0, 1, 1, 0, 5'd0, 5'd1, 1};
    vecs[7] = '{"v_reset_mid", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0};
    vecs[8] = '{"v_idle",      0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0};
    for (int unsigned i = 0; i < 9; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; hold = vecs[i].hd;
      @(negedge clk);
      check({vecs[i].name, " busy"},  busy,      vecs[i].e_busy);
      check({vecs[i].name, " valid"}, valid_out, vecs[i].e_valid);
      check({vecs[i].name, " done"},  done,      vecs[i].e_done);
      check({vecs[i].name, " row"},   row_idx,   vecs[i].e_row);
      check({vecs[i].name, " col"},   col_idx,   vecs[i].e_col);
      check({vecs[i].name, " px"},    pixel_out, vecs[i].e_px);
    end
    reset = 1'b0; start = 1'b0; hold = 1'b0;

    run_frame("checker", 0, 0, 0);

    // Random "digit" frame with random stalls.
    for (int unsigned r = 0; r < H; r++) write_row(r, W'($urandom));
    run_frame("digit_hold", 30, 0, 0);

    // Stray start/write during STREAM and DRAIN must be ignored.
    run_frame("inject", 20, 1, 0);
    run_frame("after_inject", 0, 0, 0);

    // Out-of-range row writes, then a write landing with start.
    for (int unsigned r = H; r < 32; r++) write_row(r, W'($urandom));
    run_frame("wr_with_start", 10, 0, 1);

    // Reset in the middle of row 10, then replay the whole frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(valid_out && row_idx == 5'd10 && col_idx == 5'd5) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("midreset reach_row10", guard < 1000, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy",  busy,      0);
    check("midreset valid", valid_out, 0);
    check("midreset done",  done,      0);
    check("midreset px",    pixel_out, 0);
    check("midreset row",   row_idx,   0);
    check("midreset col",   col_idx,   0);
    @(negedge clk);
    check("midreset stays_idle", busy, 0);
    run_frame("replay", 0, 0, 0);

    // Alternating all-ones / all-zeros rows: no bubble at row boundaries.
    for (int unsigned r = 0; r < H; r++) write_row(r, (r % 2 == 0) ? '1 : '0);
    run_frame("rows_alt", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
